// File: rtl/id_stage_pipe.sv
// Decode stage for RV32I-style instructions, with a registered ID/EX slot.
// Operands come from an internal register file. A write-back in the same
// cycle is forwarded to the reader. Load-use hazards insert one bubble, and a
// flush from branch resolution kills both the held and the presented instruction.
module id_stage_pipe #(
  parameter int XLEN        = 32,
  parameter int PC_SIZE     = 32,
  parameter int NREGS       = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int HAZARD_EN   = 1,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [PC_SIZE-1:0]     if_pc,
  input  logic [31:0]            if_instr,
  input  logic                   wb_we,
  input  logic [RFIDX_WIDTH-1:0] wb_idx,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   flush,
  input  logic                   ex_ready,
  output logic                   ex_valid,
  output logic [PC_SIZE-1:0]     ex_pc,
  output logic [XLEN-1:0]        ex_rs1_data,
  output logic [XLEN-1:0]        ex_rs2_data,
  output logic [XLEN-1:0]        ex_imm,
  output logic [RFIDX_WIDTH-1:0] ex_rd,
  output logic [RFIDX_WIDTH-1:0] ex_rs1,
  output logic [RFIDX_WIDTH-1:0] ex_rs2,
  output logic [3:0]             ex_alu_funct,
  output logic [1:0]             ex_alu_op,
  output logic                   ex_add2_sel,
  output logic                   ex_branch,
  output logic                   ex_jal,
  output logic                   ex_jalr,
  output logic                   ex_mem_read,
  output logic                   ex_mem_write,
  output logic [2:0]             ex_mem_mode,
  output logic                   ex_reg_write,
  output logic                   ex_memtoreg,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  // With a 16-entry file, any used index with bit 4 set names a missing register
  localparam bit NARROW_RF = (RFIDX_WIDTH < 5);

  logic [XLEN-1:0] r_rf [NREGS];

  logic [6:0]             w_opcode;
  logic [RFIDX_WIDTH-1:0] w_rd, w_rs1, w_rs2;
  logic [XLEN-1:0]        w_rs1_data, w_rs2_data, w_imm;
  logic [1:0]             w_alu_op;
  logic                   w_add2_sel, w_branch, w_jal, w_jalr;
  logic                   w_mem_read, w_mem_write, w_reg_write, w_memtoreg;
  logic                   w_uses_rs1, w_uses_rs2, w_illegal, w_hz, w_accept;

  assign w_opcode = if_instr[6:0];
  assign w_rd     = if_instr[7 +: RFIDX_WIDTH];
  assign w_rs1    = if_instr[15 +: RFIDX_WIDTH];
  assign w_rs2    = if_instr[20 +: RFIDX_WIDTH];

  // Register file: x0 stays zero, other entries take the write-back port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (wb_we && (wb_idx != '0)) begin
      r_rf[wb_idx] <= wb_data;
    end
  end

  // Forward a same-cycle write so the reader never sees a stale value
  assign w_rs1_data = (wb_we && (wb_idx == w_rs1) && (w_rs1 != '0)) ? wb_data : r_rf[w_rs1];
  assign w_rs2_data = (wb_we && (wb_idx == w_rs2) && (w_rs2 != '0)) ? wb_data : r_rf[w_rs2];

  // Decode controls and immediate; unknown opcodes keep every control at 0
  always_comb begin
    w_imm       = '0;
    w_alu_op    = 2'b00;
    w_add2_sel  = 1'b0;
    w_branch    = 1'b0;
    w_jal       = 1'b0;
    w_jalr      = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_memtoreg  = 1'b0;
    case (w_opcode)
      OP_LUI, OP_AUIPC: begin
        w_imm       = XLEN'({if_instr[31:12], 12'b0});
        w_add2_sel  = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_JAL: begin
        w_imm       = XLEN'($signed({if_instr[31], if_instr[19:12], if_instr[20],
                                     if_instr[30:21], 1'b0}));
        w_add2_sel  = 1'b1;
        w_jal       = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_JALR: begin
        w_imm       = XLEN'($signed(if_instr[31:20]));
        w_add2_sel  = 1'b1;
        w_jalr      = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_BRANCH: begin
        w_imm    = XLEN'($signed({if_instr[31], if_instr[7], if_instr[30:25],
                                  if_instr[11:8], 1'b0}));
        w_alu_op = 2'b01;
        w_branch = 1'b1;
      end
      OP_LOAD: begin
        w_imm       = XLEN'($signed(if_instr[31:20]));
        w_add2_sel  = 1'b1;
        w_mem_read  = 1'b1;
        w_reg_write = 1'b1;
        w_memtoreg  = 1'b1;
      end
      OP_STORE: begin
        w_imm       = XLEN'($signed({if_instr[31:25], if_instr[11:7]}));
        w_add2_sel  = 1'b1;
        w_mem_write = 1'b1;
      end
      OP_IMM: begin
        // Shifts carry a bare shamt; bit 30 is the arithmetic flag, not sign
        if (if_instr[13:12] == 2'b01) w_imm = XLEN'(if_instr[24:20]);
        else                          w_imm = XLEN'($signed(if_instr[31:20]));
        w_alu_op    = 2'b11;
        w_add2_sel  = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_REG: begin
        w_alu_op    = 2'b10;
        w_reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_uses_rs1 = !((w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) || (w_opcode == OP_JAL));
  assign w_uses_rs2 = (w_opcode == OP_REG) || (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);
  assign w_illegal  = NARROW_RF && ((w_reg_write && if_instr[11]) ||
                                    (w_uses_rs1 && if_instr[19]) ||
                                    (w_uses_rs2 && if_instr[24]));

  assign w_hz = (HAZARD_EN != 0) && ex_valid && ex_mem_read && (ex_rd != '0) &&
                (((ex_rd == w_rs1) && w_uses_rs1) || ((ex_rd == w_rs2) && w_uses_rs2));

  assign if_ready = !flush && !w_hz && (!ex_valid || ex_ready);
  assign w_accept = if_valid && if_ready;

  // ID/EX slot: flush beats accept, accept beats drain, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_alu_funct <= '0;
      ex_alu_op    <= '0;
      ex_add2_sel  <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jal       <= 1'b0;
      ex_jalr      <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_mem_mode  <= '0;
      ex_reg_write <= 1'b0;
      ex_memtoreg  <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (w_accept) begin
      ex_valid     <= 1'b1;
      ex_pc        <= if_pc;
      ex_rs1_data  <= w_rs1_data;
      ex_rs2_data  <= w_rs2_data;
      ex_imm       <= w_imm;
      ex_rd        <= w_rd;
      ex_rs1       <= w_rs1;
      ex_rs2       <= w_rs2;
      ex_alu_funct <= {if_instr[30], if_instr[14:12]};
      ex_alu_op    <= w_alu_op;
      ex_add2_sel  <= w_add2_sel;
      ex_branch    <= w_branch;
      ex_jal       <= w_jal;
      ex_jalr      <= w_jalr;
      ex_mem_read  <= w_mem_read && !w_illegal;
      ex_mem_write <= w_mem_write && !w_illegal;
      ex_mem_mode  <= if_instr[14:12];
      ex_reg_write <= w_reg_write && !w_illegal;
      ex_memtoreg  <= w_memtoreg;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // Saturating event counters; a flush masks any simultaneous hazard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end else if (w_hz && ex_ready) begin
      if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: reset, issue, bypass, load-use,
// backpressure/flush and immediate decoding.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
  logic        wb_we;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        flush, ex_ready, ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [3:0]  ex_alu_funct;
  logic [1:0]  ex_alu_op;
  logic        ex_add2_sel, ex_branch, ex_jal, ex_jalr;
  logic        ex_mem_read, ex_mem_write;
  logic [2:0]  ex_mem_mode;
  logic        ex_reg_write, ex_memtoreg;
  logic [15:0] stall_cnt, flush_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .wb_we(wb_we), .wb_idx(wb_idx), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_alu_funct(ex_alu_funct), .ex_alu_op(ex_alu_op), .ex_add2_sel(ex_add2_sel),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_mode(ex_mem_mode),
    .ex_reg_write(ex_reg_write), .ex_memtoreg(ex_memtoreg),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = '0;
    wb_we = 1'b0; wb_idx = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1. Reset mid-stream
    wb_we = 1'b1; wb_idx = 5'd5; wb_data = 32'h0000DEAD;
    tick();
    wb_we = 1'b0;
    present(32'h00028313, 32'h100);          // ADDI x6,x5,0
    tick();
    chk("x5_written", ex_rs1_data, 32'h0000DEAD);
    ex_ready = 1'b0;
    present(32'h00500293, 32'h104);          // ADDI x5,x0,5 (ex_ready=0 but slot drains? no: held)
    tick();
    // slot was full with ex_ready=0 so ADDI x5 waited; release and accept it
    ex_ready = 1'b1;
    #1;
    tick();
    ex_ready = 1'b0; if_valid = 1'b0;
    chk("held_imm", ex_imm, 32'd5);
    chk("held_valid", 32'(ex_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(ex_valid), 32'd0);
    chk("async_imm", ex_imm, 32'd0);
    #1 rst_n = 1'b1;
    ex_ready = 1'b1;
    tick();
    present(32'h00028313, 32'h108);          // ADDI x6,x5,0
    tick();
    chk("x5_after_rst", ex_rs1_data, 32'd0);

    // 2. Back-to-back issue
    present(32'hFFF00093, 32'h200);          // ADDI x1,x0,-1
    chk("b2b_ready0", 32'(if_ready), 32'd1);
    tick();
    chk("addi_imm", ex_imm, 32'hFFFFFFFF);
    chk("addi_rd", 32'(ex_rd), 32'd1);
    chk("addi_rw", 32'(ex_reg_write), 32'd1);
    chk("addi_add2", 32'(ex_add2_sel), 32'd1);
    chk("addi_pc", ex_pc, 32'h200);
    present(32'h00300113, 32'h204);          // ADDI x2,x0,3
    chk("b2b_ready1", 32'(if_ready), 32'd1);
    tick();
    chk("b2b_rd", 32'(ex_rd), 32'd2);
    chk("b2b_valid", 32'(ex_valid), 32'd1);

    // 3. Bypass
    wb_we = 1'b1; wb_idx = 5'd3; wb_data = 32'h00001234;
    present(32'h00318233, 32'h300);          // ADD x4,x3,x3
    tick();
    chk("byp_rs1", ex_rs1_data, 32'h00001234);
    chk("byp_rs2", ex_rs2_data, 32'h00001234);
    wb_idx = 5'd0; wb_data = 32'h00005555;
    present(32'h00000233, 32'h304);          // ADD x4,x0,x0
    tick();
    chk("x0_rs1", ex_rs1_data, 32'd0);
    wb_we = 1'b0;
    present(32'h00018233, 32'h308);          // ADD x4,x3,x0
    tick();
    chk("x3_stored", ex_rs1_data, 32'h00001234);

    // 4. Load-use
    present(32'h0000A103, 32'h400);          // LW x2,0(x1)
    tick();
    chk("lw_mread", 32'(ex_mem_read), 32'd1);
    chk("lw_m2r", 32'(ex_memtoreg), 32'd1);
    present(32'h001102B3, 32'h404);          // ADD x5,x2,x1
    chk("hz_ready", 32'(if_ready), 32'd0);
    tick();
    chk("bubble_valid", 32'(ex_valid), 32'd0);
    chk("stall_1", 32'(stall_cnt), 32'd1);
    chk("post_ready", 32'(if_ready), 32'd1);
    tick();
    chk("add_issue", 32'(ex_valid), 32'd1);
    chk("add_rd", 32'(ex_rd), 32'd5);
    chk("add_rs1", 32'(ex_rs1), 32'd2);
    present(32'h0000A003, 32'h408);          // LW x0,0(x1)
    tick();
    present(32'h001002B3, 32'h40C);          // ADD x5,x0,x1
    chk("x0_noh_ready", 32'(if_ready), 32'd1);
    tick();
    chk("x0_noh_rd", 32'(ex_rd), 32'd5);
    chk("stall_still1", 32'(stall_cnt), 32'd1);

    // 5. Backpressure then flush
    present(32'h00900393, 32'h500);          // ADDI x7,x0,9
    tick();
    ex_ready = 1'b0;
    present(32'hFE000CE3, 32'h504);          // BEQ x0,x0,-8
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", 32'(if_ready), 32'd0);
      tick();
      chk("bp_imm", ex_imm, 32'd9);
      chk("bp_valid", 32'(ex_valid), 32'd1);
    end
    flush = 1'b1;
    #1;
    tick();
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_cnt", 32'(flush_cnt), 32'd1);
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    tick();
    chk("fl_dropped", 32'(ex_valid), 32'd0);

    // 6. Immediates
    present(32'hFE63AE23, 32'h600);          // SW x6,-4(x7)
    tick();
    chk("sw_imm", ex_imm, 32'hFFFFFFFC);
    chk("sw_mwrite", 32'(ex_mem_write), 32'd1);
    chk("sw_rw", 32'(ex_reg_write), 32'd0);
    present(32'hFE000CE3, 32'h604);          // BEQ x0,x0,-8
    tick();
    chk("beq_imm", ex_imm, 32'hFFFFFFF8);
    chk("beq_branch", 32'(ex_branch), 32'd1);
    present(32'hABCDE437, 32'h608);          // LUI x8,0xABCDE
    tick();
    chk("lui_imm", ex_imm, 32'hABCDE000);
    present(32'h4074D493, 32'h60C);          // SRAI x9,x9,7
    tick();
    chk("srai_imm", ex_imm, 32'd7);
    chk("srai_funct", 32'(ex_alu_funct), 32'hD);
    present(32'hFFFFFFFF, 32'h610);          // unknown opcode
    tick();
    chk("unk_valid", 32'(ex_valid), 32'd1);
    chk("unk_rw", 32'(ex_reg_write), 32'd0);
    chk("unk_mwrite", 32'(ex_mem_write), 32'd0);
    if_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage with a registered ID/EX output: decodes RV32I-style instructions and reads operands from an internal register file with write-through bypass.
- Holds one decoded instruction toward EX under a valid/ready handshake.
- Detects load-use hazards and inserts a one-cycle bubble; supports flush from branch resolution.
- Sits between instruction fetch and the execute stage.

Parameters:
- XLEN, 32, datapath and register width.
- PC_SIZE, 32, program counter width.
- NREGS, 32, register file entries (power of two, 16 or 32).
- RFIDX_WIDTH, 5, register index width; must equal log2(NREGS).
- HAZARD_EN, 1, 1 enables load-use bubble insertion; 0 disables it (external handling).
- CNT_W, 16, width of the stall/flush event counters.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  stage accepts this cycle.
- if_pc  in  PC_SIZE  pc of the presented instruction.
- if_instr  in  32  instruction word.
- wb_we  in  1  register write enable.
- wb_idx  in  RFIDX_WIDTH  write index.
- wb_data  in  XLEN  write data.
- flush  in  1  kill the held and the presented instruction.
- ex_ready  in  1  execute consumes the held instruction.
- ex_valid  out  1  held instruction valid.
- ex_pc  out  PC_SIZE  pc.
- ex_rs1_data, ex_rs2_data  out  XLEN  operands.
- ex_imm  out  XLEN  selected sign-extended immediate (I/S/B/U/J, or zero-extended shamt).
- ex_rd, ex_rs1, ex_rs2  out  RFIDX_WIDTH  indices.
- ex_alu_funct  out  4  {instr[30], instr[14:12]}.
- ex_alu_op  out  2  ALU class.
- ex_add2_sel  out  1  second operand is immediate.
- ex_branch, ex_jal, ex_jalr  out  1 each  control-flow type.
- ex_mem_read, ex_mem_write  out  1 each  memory access type.
- ex_mem_mode  out  3  instr[14:12].
- ex_reg_write, ex_memtoreg  out  1 each  writeback control.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All ex_* outputs go to 0; ex_valid=0.
  - Register file entries go to 0.
  - Both counters go to 0.
  - A reset asserted mid-operation discards the held instruction immediately.
- Register file:
  - Entry 0 reads as 0 and ignores writes.
  - Write occurs on the rising edge when wb_we=1.
  - Read is combinational with bypass: if wb_we and wb_idx equals the rs index and the index is non-zero, the read returns wb_data in the same cycle.
  - If NREGS=16 and the upper index bit is set, that is an illegal register: decode as a no-op (ex_reg_write=0, ex_mem_read=0, ex_mem_write=0) and leave valid unchanged.
- Hazard:
  - hz = HAZARD_EN & ex_valid & ex_mem_read & (ex_rd!=0) & ((ex_rd==rs1 & uses_rs1) | (ex_rd==rs2 & uses_rs2)).
  - uses_rs1: all opcodes except LUI, AUIPC, JAL.
  - uses_rs2: opcodes R, S, B.
- if_ready = !flush & !hz & (!ex_valid | ex_ready).
- Register update, in priority order:
  - flush → ex_valid<=0; the presented instruction is dropped; flush_cnt increments, saturating.
  - Else if if_valid & if_ready → load all decoded fields; ex_valid<=1. Latency is 1 cycle from acceptance to ex_valid.
  - Else if ex_ready → ex_valid<=0. With hz set this is the bubble; stall_cnt increments, saturating.
  - Else hold all fields.
- Payload stability: ex_* payload is stable while ex_valid=1 and ex_ready=0.
- Bubble length: exactly one cycle; after the load leaves, hz deasserts because ex_valid=0.
- Unknown opcode: captured with all write/memory/branch controls at 0.
- Simultaneous wb_we write and acceptance of a reader of the same register: the registered operand equals wb_data (bypass).
- Simultaneous flush and hz: flush wins; stall_cnt does not increment.

Test Plan:
1. Reset mid-stream: ex_valid=1 holding ADDI, drop rst_n → ex_valid=0 and ex_imm=0 immediately; after release, regfile x5 reads 0.
2. Back-to-back with ex_ready=1: ADDI x1,x0,-1 (0xFFF00093) → next cycle ex_imm=0xFFFFFFFF, ex_rd=1, ex_reg_write=1, ex_add2_sel=1; one instruction per cycle, if_ready stays 1.
3. Bypass: wb_we=1, wb_idx=3, wb_data=0x1234 in the same cycle ADD x4,x3,x3 is accepted → ex_rs1_data=ex_rs2_data=0x1234; write to x0 → reads 0.
4. Load-use: LW x2 held, ex_ready=1, then ADD x5,x2,x1 presented → if_ready=0 one cycle, bubble, ADD issues the cycle after; stall_cnt=1. Same sequence with rd=x0 or HAZARD_EN=0 → no bubble.
5. Backpressure plus flush: ex_ready=0 for 3 cycles → payload unchanged and if_ready=0; assert flush → ex_valid=0 next cycle, presented BEQ dropped, flush_cnt=1.
6. Immediates: SW x6,-4(x7) → ex_imm=0xFFFFFFFC, ex_mem_write=1; BEQ offset -8 → 0xFFFFFFF8, ex_branch=1; LUI 0xABCDE → 0xABCDE000; SRAI shamt 7 → ex_imm=7, ex_alu_funct=4'b1101.
